// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CW_DEF = 21;
  localparam int unsigned DEF_TC = 99999;

  // Tick period in CLK_in cycles for a given terminal count.
  function automatic int unsigned period_of(input int unsigned tc);
    return tc + 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and status bundle for clk_div_multi; clock and reset stay outside.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = CW_DEF
);

  logic [NCH-1:0] en;
  logic [NCH-1:0] ld;
  logic [CW-1:0]  div_in;
  logic           sync;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pend;

  modport master (
    output en, ld, div_in, sync,
    input  tick, clk_out, pend
  );

  modport slave (
    input  en, ld, div_in, sync,
    output tick, clk_out, pend
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow terminal count, tick and divided clock.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CW     = CW_DEF,
  parameter int unsigned DEF_TC = clk_div_pkg::DEF_TC
) (
  input  logic          CLK_in,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] div_in,
  input  logic          sync,
  output logic          tick,
  output logic          clk_out,
  output logic          pend
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] tc;
  logic [CW-1:0] shadow;
  logic          wrap;

  assign wrap = en && (cnt == tc);

  // New divisors only reach tc at a wrap or sync, where cnt is 0,
  // so the running period is never cut short.
  always_ff @(posedge CLK_in) begin
    if (rst) begin
      cnt     <= '0;
      tc      <= CW'(DEF_TC);
      shadow  <= CW'(DEF_TC);
      pend    <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      if (ld) begin
        tc     <= div_in;
        shadow <= div_in;
      end else if (pend) begin
        tc <= shadow;
      end
    end else begin
      tick <= wrap;
      if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        pend    <= 1'b0;
        if (ld) begin
          tc     <= div_in;
          shadow <= div_in;
        end else if (pend) begin
          tc <= shadow;
        end
      end else begin
        if (en) begin
          cnt <= cnt + CW'(1);
        end
        if (ld) begin
          shadow <= div_in;
          pend   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable dividers sharing div_in, sync, clock and reset.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CW     = CW_DEF,
  parameter int unsigned DEF_TC = clk_div_pkg::DEF_TC
) (
  input  logic            CLK_in,
  input  logic            rst,
  clk_div_multi_if.slave  bus
);

  logic [NCH-1:0] tick_v;
  logic [NCH-1:0] clk_out_v;
  logic [NCH-1:0] pend_v;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CW     (CW),
      .DEF_TC (DEF_TC)
    ) u_chan (
      .CLK_in  (CLK_in),
      .rst     (rst),
      .en      (bus.en[i]),
      .ld      (bus.ld[i]),
      .div_in  (bus.div_in),
      .sync    (bus.sync),
      .tick    (tick_v[i]),
      .clk_out (clk_out_v[i]),
      .pend    (pend_v[i])
    );
  end

  assign bus.tick    = tick_v;
  assign bus.clk_out = clk_out_v;
  assign bus.pend    = pend_v;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_TC=9; expected values are hand-derived edge by edge.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  logic CLK_in = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  clk_div_multi_if #(.NCH(4), .CW(21)) bus ();

  clk_div_multi #(
    .NCH    (4),
    .CW     (21),
    .DEF_TC (9)
  ) dut (
    .CLK_in (CLK_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 CLK_in = ~CLK_in;

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge CLK_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until tick[ch] is seen; n is the number of edges taken (40 if never).
  task automatic wait_tick(input int ch, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.tick[ch] && cyc < 40);
  endtask

  initial begin
    rst        = 1'b1;
    bus.en     = '0;
    bus.ld     = '0;
    bus.sync   = 1'b0;
    bus.div_in = '0;

    // reset
    step(2);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_clk_out", 32'(bus.clk_out), 0);
    chk("rst_pend", 32'(bus.pend), 0);
    rst    = 1'b0;
    bus.en = 4'hF;
    wait_tick(0, n);                                   // edge 10
    chk("first_tick_latency", n, period_of(9));
    chk("first_tick_all", 32'(bus.tick), 4'hF);
    chk("first_clk_out", 32'(bus.clk_out), 4'hF);

    // ch0 load 3 mid-period
    bus.ld = 4'b0001; bus.div_in = 21'd3;
    step();                                            // edge 11
    chk("ld0_pend", 32'(bus.pend), 4'b0001);
    chk("ld0_no_tick", 32'(bus.tick), 0);
    bus.ld = '0;
    wait_tick(0, n);                                   // edge 20
    chk("ld0_period_kept", n, 9);
    chk("ld0_wrap_tick", 32'(bus.tick), 4'hF);
    chk("ld0_wrap_pend", 32'(bus.pend), 0);
    chk("ld0_wrap_clk", 32'(bus.clk_out), 0);
    wait_tick(0, n);                                   // edge 24
    chk("ch0_period4_a", n, 4);
    chk("ch0_clk_hi", 32'(bus.clk_out), 4'b0001);
    wait_tick(0, n);                                   // edge 28
    chk("ch0_period4_b", n, 4);
    chk("ch0_clk_lo", 32'(bus.clk_out), 0);
    step(2);                                           // edge 30
    chk("ch123_unaffected", 32'(bus.tick), 4'b1110);

    // ch1 load 2 at cnt=5
    step(5);                                           // edge 35
    bus.ld = 4'b0010; bus.div_in = 21'd2;
    step();                                            // edge 36
    chk("ld1_pend", 32'(bus.pend), 4'b0010);
    bus.ld = '0;
    step(3);                                           // edge 39
    chk("ld1_pend_held", 32'({bus.pend[1], bus.tick[1]}), 2'b10);
    step();                                            // edge 40
    chk("ld1_wrap_tick", 32'(bus.tick), 4'hF);
    chk("ld1_wrap_pend", 32'(bus.pend), 0);
    wait_tick(1, n);                                   // edge 43
    chk("ch1_period3", n, 3);
    chk("ch1_tick_only", 32'(bus.tick), 4'b0010);
    step();                                            // edge 44
    chk("ch0_tick_44", 32'(bus.tick), 4'b0001);
    step(2);                                           // edge 46
    chk("ch1_tick_46", 32'(bus.tick), 4'b0010);

    // ch2 load 0 coincident with its wrap
    step(3);                                           // edge 49
    bus.ld = 4'b0100; bus.div_in = '0;
    step();                                            // edge 50
    chk("coinc_tick", 32'(bus.tick), 4'b1100);
    chk("coinc_pend", 32'(bus.pend), 0);
    chk("coinc_clk", 32'(bus.clk_out), 4'hF);
    bus.ld = '0;
    step();                                            // edge 51
    chk("tc0_a", 32'({bus.tick[2], bus.clk_out[2]}), 2'b10);
    step();                                            // edge 52
    chk("tc0_b_tick", 32'(bus.tick), 4'b0111);
    chk("tc0_b_clk", 32'(bus.clk_out[2]), 1);
    bus.en = 4'b1011;
    step();                                            // edge 53
    chk("hold_a", 32'({bus.tick[2], bus.clk_out[2]}), 2'b01);
    step();                                            // edge 54
    chk("hold_b", 32'({bus.tick[2], bus.clk_out[2]}), 2'b01);

    // sync with a pending divisor on ch1
    step();                                            // edge 55
    bus.ld = 4'b0010; bus.div_in = 21'd5;
    step();                                            // edge 56
    chk("sync_pre_pend", 32'(bus.pend), 4'b0010);
    bus.ld = '0; bus.sync = 1'b1;
    step();                                            // edge 57
    chk("sync_tick", 32'(bus.tick), 0);
    chk("sync_clk", 32'(bus.clk_out), 0);
    chk("sync_pend", 32'(bus.pend), 0);
    bus.sync = 1'b0;
    wait_tick(0, n);                                   // edge 61
    chk("sync_ch0_first", n, 4);
    chk("sync_ch0_tick", 32'(bus.tick), 4'b0001);
    wait_tick(1, n);                                   // edge 63
    chk("sync_ch1_first", n, 2);
    chk("sync_ch1_tick", 32'(bus.tick), 4'b0010);
    chk("sync_ch1_clk", 32'(bus.clk_out), 4'b0011);

    // reset beats sync and ld
    rst = 1'b1; bus.ld = 4'hF; bus.sync = 1'b1; bus.div_in = 21'd1;
    step();
    chk("rst_win_tick", 32'(bus.tick), 0);
    chk("rst_win_clk", 32'(bus.clk_out), 0);
    chk("rst_win_pend", 32'(bus.pend), 0);
    rst = 1'b0; bus.ld = '0; bus.sync = 1'b0; bus.en = 4'hF;

    // two loads before a wrap: the later one wins
    bus.ld = 4'b0001; bus.div_in = 21'd7;
    step();                                            // edge 1
    chk("ld_twice_pend", 32'(bus.pend), 4'b0001);
    bus.div_in = 21'd1;
    step();                                            // edge 2
    bus.ld = '0;
    wait_tick(0, n);                                   // edge 10
    chk("rst_win_period", n, 8);
    chk("rst_win_all_tick", 32'(bus.tick), 4'hF);
    wait_tick(0, n);                                   // edge 12
    chk("last_ld_wins_a", n, 2);
    wait_tick(0, n);                                   // edge 14
    chk("last_ld_wins_b", n, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
